// File: rtl/reg_file.sv
// Architectural register file with two bypassed read ports, a return-PC
// register and a per-register busy scoreboard for read-after-write stalls.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb,
    input  logic              ret_we,
    input  logic [DATA_W-1:0] nxt_ret_PC,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] ret_PC,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              hazard
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [DATA_W-1:0] ret_pc_q;
    logic [DATA_W-1:0] ret_pc_d;

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wb_addr] = wb;
        end
    end

    // Clear first so a same-address issue (the newer producer) wins.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue_we) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_comb begin
        ret_pc_d = ret_we ? nxt_ret_PC : ret_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q   <= '0;
            ret_pc_q <= '0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            ret_pc_q <= ret_pc_d;
        end
    end

    always_comb begin
        rs1_hit  = we && (wb_addr == rs1_addr);
        rs2_hit  = we && (wb_addr == rs2_addr);
        rs1_data = rs1_hit ? wb : regs_q[rs1_addr];
        rs2_data = rs2_hit ? wb : regs_q[rs2_addr];
        hazard   = (busy_q[rs1_addr] && !rs1_hit) ||
                   (busy_q[rs2_addr] && !rs2_hit);
    end

    assign ret_PC = ret_pc_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios followed by random traffic,
// all checked against an array-based reference model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  wb_addr;
    logic [15:0] wb;
    logic        ret_we;
    logic [15:0] nxt_ret_PC;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] ret_PC;
    logic        issue_we;
    logic [3:0]  issue_addr;
    logic        hazard;

    reg_file #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wb_addr    (wb_addr),
        .wb         (wb),
        .ret_we     (ret_we),
        .nxt_ret_PC (nxt_ret_PC),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .ret_PC     (ret_PC),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .hazard     (hazard)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m_regs [16];
    bit   [15:0] m_busy;
    logic [15:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
        m_ret  = '0;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        return (we && wb_addr == a) ? wb : m_regs[a];
    endfunction

    function automatic logic m_src_stall(input logic [3:0] a);
        return m_busy[a] && !(we && wb_addr == a);
    endfunction

    function automatic logic m_hazard();
        return m_src_stall(rs1_addr) || m_src_stall(rs2_addr);
    endfunction

    // Rising edge as the model sees it: retire, then issue.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (we) begin
                m_regs[wb_addr] = wb;
                m_busy[wb_addr] = 1'b0;
            end
            if (issue_we) m_busy[issue_addr] = 1'b1;
            if (ret_we) m_ret = nxt_ret_PC;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".rs1"}, 32'(rs1_data), 32'(m_read(rs1_addr)));
        chk({tag, ".rs2"}, 32'(rs2_data), 32'(m_read(rs2_addr)));
        chk({tag, ".ret"}, 32'(ret_PC), 32'(m_ret));
        chk({tag, ".hz"},  32'(hazard), 32'(m_hazard()));
    endtask

    task automatic idle();
        we = 0; ret_we = 0; issue_we = 0;
    endtask

    initial begin
        model_reset();
        rst = 1; we = 1; wb_addr = 3; wb = 16'hBEEF;
        ret_we = 0; nxt_ret_PC = 0; issue_we = 0; issue_addr = 0;
        rs1_addr = 3; rs2_addr = 0;
        @(negedge clk);
        tick();
        rst = 0; idle();
        #1;
        chk("rst.rs1", 32'(rs1_data), 32'h0);
        chk("rst.ret", 32'(ret_PC), 32'h0);
        chk("rst.hz", 32'(hazard), 32'h0);

        // write/read with same-cycle bypass
        we = 1; wb_addr = 0; wb = 16'h0001;
        ret_we = 1; nxt_ret_PC = 16'h0001; rs1_addr = 0;
        #1;
        chk("wr.bypass", 32'(rs1_data), 32'h1);
        tick();
        idle();
        #1;
        chk("wr.stored", 32'(rs1_data), 32'h1);
        chk("wr.ret", 32'(ret_PC), 32'h1);

        // dual-port bypass
        we = 1; wb_addr = 5; wb = 16'h0005; tick();
        wb_addr = 6; wb = 16'h0006; tick();
        wb_addr = 6; wb = 16'h1234; rs1_addr = 5; rs2_addr = 6;
        #1;
        chk("dual.rs1", 32'(rs1_data), 32'h0005);
        chk("dual.rs2", 32'(rs2_data), 32'h1234);
        tick();
        idle();

        // hazard and bypass release
        issue_we = 1; issue_addr = 7; tick();
        idle(); rs1_addr = 0; rs2_addr = 7;
        #1;
        chk("hz.set", 32'(hazard), 32'h1);
        we = 1; wb_addr = 7; wb = 16'h00AA;
        #1;
        chk("hz.bypass", 32'(hazard), 32'h0);
        chk("hz.rs2", 32'(rs2_data), 32'h00AA);
        tick();
        idle();
        #1;
        chk("hz.clear", 32'(hazard), 32'h0);

        // set/clear collision on one address
        issue_we = 1; issue_addr = 9; tick();
        idle(); rs1_addr = 9; rs2_addr = 0;
        we = 1; wb_addr = 9; wb = 16'h0099;
        issue_we = 1; issue_addr = 9;
        tick();
        idle();
        #1;
        chk("coll.busy", 32'(hazard), 32'h1);
        we = 1; wb_addr = 9; wb = 16'h0099; tick();
        idle();

        // async reset between edges
        we = 1; wb_addr = 2; wb = 16'hFFFF; tick();
        idle(); issue_we = 1; issue_addr = 2; tick();
        idle(); rs1_addr = 2; rs2_addr = 2;
        #1;
        chk("ar.pre.rs1", 32'(rs1_data), 32'hFFFF);
        chk("ar.pre.hz", 32'(hazard), 32'h1);
        #1 rst = 1;
        model_reset();
        #1;
        chk("ar.rs1", 32'(rs1_data), 32'h0);
        chk("ar.hz", 32'(hazard), 32'h0);
        chk("ar.ret", 32'(ret_PC), 32'h0);
        tick();
        rst = 0;

        // random traffic, decode obeys the stall rule
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            we         = $urandom_range(0, 1) == 1;
            wb_addr    = 4'($urandom);
            wb         = 16'($urandom);
            ret_we     = $urandom_range(0, 3) == 0;
            nxt_ret_PC = 16'($urandom);
            rs1_addr   = 4'($urandom);
            rs2_addr   = 4'($urandom);
            issue_addr = 4'($urandom);
            issue_we   = ($urandom_range(0, 2) == 0) && !m_hazard();
            if (rst) model_reset();
            check_all("rnd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
